// File: rtl/branch_ctrl.sv
// branch_ctrl: redirect/flush/halt control for a simple fetch unit with a return-address stack.
module branch_ctrl #(
  parameter int D     = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [D-1:0]               imm,
  input  logic                       zero,
  input  logic [D-1:0]               pc_cur,
  input  logic                       resume,
  output logic                       jumpEn,
  output logic [D-1:0]               target,
  output logic                       flush,
  output logic                       halted,
  output logic                       stack_ovf,
  output logic                       stack_unf,
  output logic [$clog2(DEPTH+1)-1:0] depth
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t         state_q, state_d;
  logic [D-1:0]   target_q, target_d;
  logic [DW-1:0]  depth_q, depth_d, top;
  logic           ovf_q, ovf_d, unf_q, unf_d, push;
  logic [D-1:0]   stk_q [DEPTH];
  assign top       = depth_q - DW'(1);
  assign jumpEn    = state_q != RUN;
  assign flush     = state_q != RUN;
  assign halted    = state_q == HALT;
  assign target    = target_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
  assign depth     = depth_q;
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push     = 1'b0;
    case (state_q)
      RUN: if (op_valid) begin
        case (op)
          3'b001: begin
            state_d  = FLUSH;
            target_d = imm;
          end
          3'b010, 3'b011: if (zero == (op == 3'b010)) begin
            state_d  = FLUSH;
            target_d = pc_cur + imm;
          end
          3'b100: begin
            state_d  = FLUSH;
            target_d = imm;
            if (depth_q == DW'(DEPTH)) ovf_d = 1'b1;
            else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
            end
          end
          3'b101: if (depth_q == '0) unf_d = 1'b1;
          else begin
            state_d  = FLUSH;
            target_d = stk_q[top[AW-1:0]];
            depth_d  = top;
          end
          3'b110: begin
            state_d  = HALT;
            target_d = pc_cur + D'(1);
          end
          default: ;
        endcase
      end
      FLUSH:   state_d = RUN;
      HALT:    state_d = resume ? RUN : HALT;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      target_q <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  // Stack contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) stk_q[depth_q[AW-1:0]] <= pc_cur + D'(1);
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed self-checking bench for branch_ctrl (D=6, DEPTH=4).
module tb_branch_ctrl;
  logic       clk = 1'b0;
  logic       reset, op_valid, zero, resume;
  logic [2:0] op;
  logic [5:0] imm, pc_cur, target;
  logic       jumpEn, flush, halted, stack_ovf, stack_unf;
  logic [2:0] depth;
  int checks = 0;
  int passes = 0;

  branch_ctrl #(.D(6), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .imm(imm), .zero(zero),
    .pc_cur(pc_cur), .resume(resume), .jumpEn(jumpEn), .target(target), .flush(flush),
    .halted(halted), .stack_ovf(stack_ovf), .stack_unf(stack_unf), .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] o, input logic [5:0] i, input logic z, input logic [5:0] p);
    op_valid = 1'b1;
    op = o;
    imm = i;
    zero = z;
    pc_cur = p;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; op_valid = 1'b0; op = 3'b000; imm = '0; zero = 1'b0; pc_cur = '0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({jumpEn, flush, halted, stack_ovf, stack_unf, target, depth} !== 14'd0)
      $display("FAIL reset_state got %b exp 0", {jumpEn, flush, halted, stack_ovf, stack_unf, target, depth});
    else passes++;
  endtask

  task automatic test_branch;
    req(3'b010, 6'h3D, 1'b1, 6'd10);
    checks++;
    if ({jumpEn, flush, halted, target} !== {3'b110, 6'd7})
      $display("FAIL bz_taken got %b/%0d exp 110/7", {jumpEn, flush, halted}, target);
    else passes++;
    tick();
    checks++;
    if ({jumpEn, flush} !== 2'b00) $display("FAIL bz_after got %b exp 00", {jumpEn, flush});
    else passes++;
    req(3'b010, 6'h3D, 1'b0, 6'd10);
    checks++;
    if ({jumpEn, flush} !== 2'b00) $display("FAIL bz_not_taken got %b exp 00", {jumpEn, flush});
    else passes++;
    req(3'b011, 6'd4, 1'b1, 6'd10);
    checks++;
    if ({jumpEn, flush} !== 2'b00) $display("FAIL bnz_not_taken got %b exp 00", {jumpEn, flush});
    else passes++;
  endtask

  task automatic test_wrap;
    req(3'b011, 6'd5, 1'b0, 6'd62);
    checks++;
    if ({jumpEn, flush, target} !== {2'b11, 6'd3})
      $display("FAIL bnz_wrap got %b/%0d exp 11/3", {jumpEn, flush}, target);
    else passes++;
    tick();
  endtask

  task automatic test_jump;
    req(3'b001, 6'd33, 1'b0, 6'd1);
    checks++;
    if ({jumpEn, flush, target} !== {2'b11, 6'd33})
      $display("FAIL jump got %b/%0d exp 11/33", {jumpEn, flush}, target);
    else passes++;
    req(3'b001, 6'd12, 1'b0, 6'd2);
    checks++;
    if ({jumpEn, flush} !== 2'b00) $display("FAIL op_in_flush got %b exp 00", {jumpEn, flush});
    else passes++;
    req(3'b111, 6'd12, 1'b0, 6'd2);
    checks++;
    if ({jumpEn, flush} !== 2'b00) $display("FAIL op_111 got %b exp 00", {jumpEn, flush});
    else passes++;
    op = 3'b001;
    tick();
    checks++;
    if ({jumpEn, flush} !== 2'b00) $display("FAIL op_invalid got %b exp 00", {jumpEn, flush});
    else passes++;
  endtask

  task automatic test_call_ret;
    logic [5:0] exp_t [4] = '{6'd20, 6'd40, 6'd22, 6'd5};
    logic [2:0] exp_d [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    logic [2:0] ops   [4] = '{3'b100, 3'b100, 3'b101, 3'b101};
    logic [5:0] imms  [4] = '{6'd20, 6'd40, 6'd0, 6'd0};
    logic [5:0] pcs   [4] = '{6'd4, 6'd21, 6'd41, 6'd23};
    for (int k = 0; k < 4; k++) begin
      req(ops[k], imms[k], 1'b0, pcs[k]);
      checks++;
      if ({jumpEn, target, depth} !== {1'b1, exp_t[k], exp_d[k]})
        $display("FAIL call_ret_%0d got j=%b t=%0d d=%0d exp j=1 t=%0d d=%0d", k, jumpEn, target, depth, exp_t[k], exp_d[k]);
      else passes++;
      tick();
    end
  endtask

  task automatic test_stack;
    for (int k = 0; k < 5; k++) begin
      req(3'b100, 6'd10 + 6'(k), 1'b0, 6'(k));
      checks++;
      if ({jumpEn, target, depth, stack_ovf} !== {1'b1, 6'd10 + 6'(k), (k < 4) ? 3'(k + 1) : 3'd4, k == 4})
        $display("FAIL push_%0d got j=%b t=%0d d=%0d ovf=%b", k, jumpEn, target, depth, stack_ovf);
      else passes++;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      req(3'b101, 6'd0, 1'b0, 6'd50);
      checks++;
      if ({jumpEn, target, depth} !== {1'b1, 6'(4 - k), 3'(3 - k)})
        $display("FAIL pop_%0d got j=%b t=%0d d=%0d exp j=1 t=%0d d=%0d", k, jumpEn, target, depth, 4 - k, 3 - k);
      else passes++;
      tick();
    end
    req(3'b101, 6'd0, 1'b0, 6'd50);
    checks++;
    if ({jumpEn, flush, stack_unf, stack_ovf, depth} !== {4'b0011, 3'd0})
      $display("FAIL underflow got j=%b f=%b unf=%b ovf=%b d=%0d exp 0 0 1 1 0", jumpEn, flush, stack_unf, stack_ovf, depth);
    else passes++;
  endtask

  task automatic test_halt;
    req(3'b110, 6'd0, 1'b0, 6'd9);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({jumpEn, flush, halted, target, depth} !== {3'b111, 6'd10, 3'd0})
        $display("FAIL halt_hold_%0d got %b/%0d/%0d exp 111/10/0", k, {jumpEn, flush, halted}, target, depth);
      else passes++;
      op_valid = k[0];
      op = k[1] ? 3'b100 : 3'b001;
      imm = 6'(k);
      tick();
    end
    op_valid = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if ({jumpEn, flush, halted, depth} !== 6'd0)
      $display("FAIL resume got %b d=%0d exp 000 d=0", {jumpEn, flush, halted}, depth);
    else passes++;
  endtask

  task automatic test_async_reset;
    req(3'b100, 6'd30, 1'b0, 6'd7);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({jumpEn, flush, halted, stack_ovf, stack_unf, target, depth} !== 14'd0)
      $display("FAIL reset_in_flush got %b exp 0", {jumpEn, flush, halted, stack_ovf, stack_unf, target, depth});
    else passes++;
    op_valid = 1'b1;
    op = 3'b001;
    imm = 6'd17;
    tick();
    checks++;
    if ({jumpEn, flush, target} !== 8'd0)
      $display("FAIL req_in_reset got %b/%0d exp 00/0", {jumpEn, flush}, target);
    else passes++;
    op_valid = 1'b0;
    reset = 1'b0;
    req(3'b110, 6'd0, 1'b0, 6'd20);
    checks++;
    if ({halted, target} !== {1'b1, 6'd21}) $display("FAIL halt_enter got %b/%0d exp 1/21", halted, target);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({jumpEn, flush, halted, stack_ovf, stack_unf, target, depth} !== 14'd0)
      $display("FAIL reset_in_halt got %b exp 0", {jumpEn, flush, halted, stack_ovf, stack_unf, target, depth});
    else passes++;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({jumpEn, flush, halted} !== 3'b000) $display("FAIL after_reset got %b exp 000", {jumpEn, flush, halted});
    else passes++;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_wrap();
    test_jump();
    test_call_ret();
    test_stack();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
